// File: rtl/dload_align_pkg.sv
// Shared symbols for the load-align block: access-width one-hot bit positions,
// captured-width reset value and FSM state encodings.
package dload_align_pkg;

    localparam int RALU_WWIDTH = 3;
    localparam int RALU_NONE   = 0;
    localparam int RALU_BYTE   = 1;
    localparam int RALU_HALF   = 2;
    localparam int RALU_WORD   = 3;

    typedef logic [RALU_WWIDTH:0] width_t;

    localparam width_t RALU_WIDTH_INIT = width_t'(1 << RALU_NONE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dl_state_e;

    // A width with the NONE bit set, or with no size bit at all, is not a memory access.
    function automatic logic is_mem_width(input width_t w);
        return ~w[RALU_NONE] & (w[RALU_BYTE] | w[RALU_HALF] | w[RALU_WORD]);
    endfunction

endpackage

// File: rtl/dload_align_if.sv
// E/M-stage load handshake between the pipeline/memory side and dload_align.
interface dload_align_if;
    import dload_align_pkg::*;

    logic        clmi_rhold;
    logic        dread_e;
    width_t      width_e_p;
    logic        signed_e;
    logic [1:0]  daddr_e;
    logic        dadalerr_e;
    logic [31:0] ddata_m;
    logic        dvalid_m;
    logic        dstall_m;
    logic [31:0] ldata_m_r;
    logic        ldvalid_m_r;
    logic        ldexc_m_r;

    modport slave (
        input  clmi_rhold, dread_e, width_e_p, signed_e, daddr_e, dadalerr_e,
        input  ddata_m, dvalid_m,
        output dstall_m, ldata_m_r, ldvalid_m_r, ldexc_m_r
    );

    modport master (
        output clmi_rhold, dread_e, width_e_p, signed_e, daddr_e, dadalerr_e,
        output ddata_m, dvalid_m,
        input  dstall_m, ldata_m_r, ldvalid_m_r, ldexc_m_r
    );

endinterface

// File: rtl/dload_align_extract.sv
// Big-endian lane select and sign/zero extension of a memory read word; purely combinational.
module dload_extract
    import dload_align_pkg::*;
(
    input  width_t      i_width,
    input  logic [1:0]  i_off,
    input  logic        i_signed,
    input  logic [31:0] i_data,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_data[31:24];
        unique case (i_off)
            2'd0: w_byte = i_data[31:24];
            2'd1: w_byte = i_data[23:16];
            2'd2: w_byte = i_data[15:8];
            2'd3: w_byte = i_data[7:0];
            default: w_byte = i_data[31:24];
        endcase
        w_half = i_off[1] ? i_data[15:0] : i_data[31:16];

        o_data = '0;
        if (i_width[RALU_NONE])
            o_data = '0;
        else if (i_width[RALU_WORD])
            o_data = i_data;
        else if (i_width[RALU_HALF])
            o_data = {{16{i_signed & w_half[15]}}, w_half};
        else if (i_width[RALU_BYTE])
            o_data = {{24{i_signed & w_byte[7]}}, w_byte};
    end

endmodule

// File: rtl/dload_align.sv
// M-stage load alignment: tracks one outstanding load, stalls until memory data
// arrives, then registers the aligned/extended result until the next advance.
module dload_align
    import dload_align_pkg::*;
(
    input  logic         i_sysclk,
    input  logic         i_reset_d1_r_n,
    dload_align_if.slave bus
);

    dl_state_e   r_state;
    dl_state_e   w_next;
    width_t      r_width;
    logic [1:0]  r_off;
    logic        r_signed;
    logic [31:0] r_ldata;
    logic        r_ldvalid;
    logic        r_ldexc;

    logic        w_adv;
    logic        w_e_open;
    logic        w_accept;
    logic        w_exc;
    logic [31:0] w_ext;

    // E-stage inputs are only looked at while no load is waiting on memory.
    assign w_adv    = ~bus.clmi_rhold;
    assign w_e_open = (r_state != ST_WAIT);
    assign w_accept = w_adv & w_e_open & bus.dread_e & ~bus.dadalerr_e & is_mem_width(bus.width_e_p);
    assign w_exc    = w_e_open & bus.dread_e & bus.dadalerr_e;

    always_ff @(posedge i_sysclk or negedge i_reset_d1_r_n) begin
        if (!i_reset_d1_r_n) r_state <= ST_IDLE;
        else                 r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_WAIT;
            ST_WAIT: if (bus.dvalid_m) w_next = ST_DONE;
            ST_DONE: begin
                if (w_accept)   w_next = ST_WAIT;
                else if (w_adv) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_sysclk or negedge i_reset_d1_r_n) begin
        if (!i_reset_d1_r_n) begin
            r_width  <= RALU_WIDTH_INIT;
            r_off    <= '0;
            r_signed <= 1'b0;
        end else if (w_accept) begin
            r_width  <= bus.width_e_p;
            r_off    <= bus.daddr_e;
            r_signed <= bus.signed_e;
        end
    end

    dload_extract u_extract (
        .i_width  (r_width),
        .i_off    (r_off),
        .i_signed (r_signed),
        .i_data   (bus.ddata_m),
        .o_data   (w_ext)
    );

    always_ff @(posedge i_sysclk or negedge i_reset_d1_r_n) begin
        if (!i_reset_d1_r_n) begin
            r_ldata   <= '0;
            r_ldvalid <= 1'b0;
            r_ldexc   <= 1'b0;
        end else begin
            if (r_state == ST_WAIT && bus.dvalid_m) begin
                r_ldata   <= w_ext;
                r_ldvalid <= 1'b1;
            end else if (r_state == ST_DONE && w_adv) begin
                r_ldvalid <= 1'b0;
            end
            if (w_adv) r_ldexc <= w_exc;
        end
    end

    assign bus.dstall_m    = (r_state == ST_WAIT);
    assign bus.ldata_m_r   = r_ldata;
    assign bus.ldvalid_m_r = r_ldvalid;
    assign bus.ldexc_m_r   = r_ldexc;

endmodule

// File: tb/tb_dload_align.sv
// Bench for dload_align: directed scenarios plus random traffic against a
// transaction-level model of outstanding load / result / exception.
module tb_dload_align;
    import dload_align_pkg::*;

    logic gclk = 1'b0;
    logic grst_n = 1'b0;
    always #5 gclk = ~gclk;

    dload_align_if bus ();

    dload_align dut (
        .i_sysclk       (gclk),
        .i_reset_d1_r_n (grst_n),
        .bus            (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    // model: a load is either waiting on memory or not; result/exc are what the outputs should show
    bit          m_busy, m_valid, m_exc;
    logic [31:0] m_data;
    int          m_nbytes;
    int          m_off;
    bit          m_sgn;

    localparam width_t W_NONE = width_t'(1 << RALU_NONE);
    localparam width_t W_BYTE = width_t'(1 << RALU_BYTE);
    localparam width_t W_HALF = width_t'(1 << RALU_HALF);
    localparam width_t W_WORD = width_t'(1 << RALU_WORD);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_extract(input int nb, input int off, input bit sgn,
                                                input logic [31:0] d);
        logic [31:0] v;
        if (nb == 4) return d;
        if (nb == 2) begin
            v = (off < 2) ? (d >> 16) : (d & 32'h0000_FFFF);
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
            return v;
        end
        v = (d >> (8 * (3 - off))) & 32'h0000_00FF;
        if (sgn && v[7]) v = v | 32'hFFFF_FF00;
        return v;
    endfunction

    task automatic mdl_reset();
        m_busy = 0; m_valid = 0; m_exc = 0; m_data = '0;
    endtask

    task automatic mdl_edge(input logic rh, input logic dr, input width_t w, input logic sg,
                            input logic [1:0] ad, input logic ae, input logic [31:0] dd,
                            input logic dv);
        bit adv      = !rh;
        bit was_busy = m_busy;
        if (was_busy) begin
            if (dv) begin
                m_data  = ref_extract(m_nbytes, m_off, m_sgn, dd);
                m_valid = 1;
                m_busy  = 0;
            end
        end else if (adv) begin
            m_valid = 0;
            if (dr && !ae && !w[RALU_NONE]) begin
                m_busy   = 1;
                m_nbytes = w[RALU_BYTE] ? 1 : (w[RALU_HALF] ? 2 : 4);
                m_off    = int'(ad);
                m_sgn    = sg;
            end
        end
        if (adv) m_exc = !was_busy && dr && ae;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dstall"},  32'(bus.dstall_m),    32'(m_busy));
        chk({tag, ".ldvalid"}, 32'(bus.ldvalid_m_r), 32'(m_valid));
        chk({tag, ".ldexc"},   32'(bus.ldexc_m_r),   32'(m_exc));
        if (m_valid) chk({tag, ".ldata"}, bus.ldata_m_r, m_data);
    endtask

    // Drive one cycle of inputs just after a falling edge, step the model, check at the next falling edge.
    task automatic cyc(input string tag, input logic rh, input logic dr, input width_t w,
                       input logic sg, input logic [1:0] ad, input logic ae,
                       input logic [31:0] dd, input logic dv);
        bus.clmi_rhold = rh; bus.dread_e = dr; bus.width_e_p = w; bus.signed_e = sg;
        bus.daddr_e = ad; bus.dadalerr_e = ae; bus.ddata_m = dd; bus.dvalid_m = dv;
        mdl_edge(rh, dr, w, sg, ad, ae, dd, dv);
        @(negedge gclk);
        check_all(tag);
    endtask

    task automatic idle(input string tag, input logic rh, input logic [31:0] dd, input logic dv);
        cyc(tag, rh, 1'b0, W_NONE, 1'b0, 2'd0, 1'b0, dd, dv);
    endtask

    initial begin
        width_t wsel [4];
        wsel[0] = W_NONE; wsel[1] = W_BYTE; wsel[2] = W_HALF; wsel[3] = W_WORD;
        bus.clmi_rhold = 0; bus.dread_e = 0; bus.width_e_p = W_NONE; bus.signed_e = 0;
        bus.daddr_e = 0; bus.dadalerr_e = 0; bus.ddata_m = 0; bus.dvalid_m = 0;
        mdl_reset();
        repeat (2) @(negedge gclk);
        chk("rst.dstall",  32'(bus.dstall_m), 0);
        chk("rst.ldata",   bus.ldata_m_r, 0);
        chk("rst.ldvalid", 32'(bus.ldvalid_m_r), 0);
        chk("rst.ldexc",   32'(bus.ldexc_m_r), 0);
        grst_n = 1'b1;

        // signed byte, offset 1, data two cycles after accept
        cyc("b1.acc", 0, 1, W_BYTE, 1, 2'd1, 0, 32'h0, 0);
        chk("b1.stall0", 32'(bus.dstall_m), 1);
        idle("b1.w", 0, 32'h0, 0);
        chk("b1.stall1", 32'(bus.dstall_m), 1);
        idle("b1.dv", 0, 32'h1280_3456, 1);
        chk("b1.data", bus.ldata_m_r, 32'hFFFF_FF80);
        chk("b1.valid", 32'(bus.ldvalid_m_r), 1);
        idle("b1.adv", 0, 32'h0, 0);

        // unsigned half, offset 2
        cyc("h2.acc", 0, 1, W_HALF, 0, 2'd2, 0, 32'h0, 0);
        idle("h2.dv", 0, 32'h1234_ABCD, 1);
        chk("h2.data", bus.ldata_m_r, 32'h0000_ABCD);
        idle("h2.adv", 0, 32'h0, 0);

        // word with data arriving under hold, result held three cycles
        cyc("w.acc", 0, 1, W_WORD, 0, 2'd0, 0, 32'h0, 0);
        idle("w.dv", 1, 32'hCAFE_F00D, 1);
        idle("w.h1", 1, 32'h0, 0);
        idle("w.h2", 1, 32'h0, 0);
        chk("w.held", bus.ldata_m_r, 32'hCAFE_F00D);
        chk("w.heldv", 32'(bus.ldvalid_m_r), 1);
        idle("w.adv", 0, 32'h0, 0);
        chk("w.clr", 32'(bus.ldvalid_m_r), 0);

        // misaligned word
        cyc("ae", 0, 1, W_WORD, 0, 2'd3, 1, 32'h0, 0);
        chk("ae.exc", 32'(bus.ldexc_m_r), 1);
        chk("ae.stall", 32'(bus.dstall_m), 0);
        idle("ae.adv", 0, 32'h0, 0);
        chk("ae.clr", 32'(bus.ldexc_m_r), 0);

        // back-to-back bytes
        cyc("bb.a1", 0, 1, W_BYTE, 0, 2'd0, 0, 32'h0, 0);
        idle("bb.d1", 0, 32'h89AB_CDEF, 1);
        chk("bb.r1", bus.ldata_m_r, 32'h0000_0089);
        cyc("bb.a2", 0, 1, W_BYTE, 1, 2'd3, 0, 32'h0, 0);
        chk("bb.stall", 32'(bus.dstall_m), 1);
        idle("bb.d2", 0, 32'h0102_03F4, 1);
        chk("bb.r2", bus.ldata_m_r, 32'hFFFF_FFF4);
        idle("bb.adv", 0, 32'h0, 0);

        // reset while waiting abandons the load
        cyc("rw.acc", 0, 1, W_WORD, 0, 2'd0, 0, 32'h0, 0);
        #2 grst_n = 1'b0;
        #1;
        mdl_reset();
        chk("rw.stall", 32'(bus.dstall_m), 0);
        chk("rw.ldata", bus.ldata_m_r, 0);
        chk("rw.valid", 32'(bus.ldvalid_m_r), 0);
        @(negedge gclk);
        grst_n = 1'b1;
        idle("rw.dv", 0, 32'hDEAD_BEEF, 1);
        chk("rw.ldata2", bus.ldata_m_r, 0);
        idle("rw.post", 0, 32'h0, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc("rnd", ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                wsel[$urandom_range(0, 3)], $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 6) == 0), $urandom, ($urandom_range(0, 4) < 2));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
